vector_source_arbiter: RTL

//  Shares one displacement-accumulator input port between two vector sources.

---
 rtl/vector_source_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vector_source_arbiter.sv
// Purpose: round-robin share of one downstream (dx,dy) port between two dav_/rfd sources.
// Latency: grant 1 edge after a source dav_ falls; downstream dav_ falls 2 edges after that source releases.
// Backpressure: the winner's rfd stays low until downstream completes its handshake; the loser waits in place.
// Optional feature: define ARB_STATS_EN to add the per-source transaction counters cnt0/cnt1.
module vector_source_arbiter #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav0_,
  input  logic [W-1:0] dx0,
  input  logic [W-1:0] dy0,
  output logic         rfd0,
  input  logic         dav1_,
  input  logic [W-1:0] dx1,
  input  logic [W-1:0] dy1,
  output logic         rfd1,
  output logic         dav_,
  output logic [W-1:0] dx,
  output logic [W-1:0] dy,
  input  logic         rfd,
  output logic         gnt,
  output logic         busy
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP_REL = 2'd1,
    DN_REQ = 2'd2,
    DN_ACK = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic         prio, prio_nxt;
  logic [W-1:0] dx_nxt, dy_nxt;
  logic         gnt_nxt, busy_nxt, rfd0_nxt, rfd1_nxt, dav_nxt;
  logic         req0, req1, win, src_rel;

  // Next-state and next-output decode; every register holds unless its state acts on it.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    dx_nxt    = dx;
    dy_nxt    = dy;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    rfd0_nxt  = rfd0;
    rfd1_nxt  = rfd1;
    dav_nxt   = dav_;
    req0      = ~dav0_;
    req1      = ~dav1_;
    // On a tie the priority source wins; otherwise whichever is requesting.
    win       = (req0 && req1) ? prio : req1;
    src_rel   = gnt ? dav1_ : dav0_;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          dx_nxt    = win ? dx1 : dx0;
          dy_nxt    = win ? dy1 : dy0;
          gnt_nxt   = win;
          busy_nxt  = 1'b1;
          if (win) rfd1_nxt = 1'b0;
          else     rfd0_nxt = 1'b0;
          state_nxt = UP_REL;
        end
      end
      UP_REL: begin
        if (src_rel) state_nxt = DN_REQ;
      end
      DN_REQ: begin
        if (rfd) begin
          dav_nxt   = 1'b0;
          state_nxt = DN_ACK;
        end
      end
      DN_ACK: begin
        if (!rfd) begin
          dav_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          prio_nxt  = ~gnt;
          if (gnt) rfd1_nxt = 1'b1;
          else     rfd0_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight pair.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= IDLE;
      prio  <= 1'b0;
      dx    <= '0;
      dy    <= '0;
      gnt   <= 1'b0;
      busy  <= 1'b0;
      rfd0  <= 1'b1;
      rfd1  <= 1'b1;
      dav_  <= 1'b1;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      dx    <= dx_nxt;
      dy    <= dy_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      rfd0  <= rfd0_nxt;
      rfd1  <= rfd1_nxt;
      dav_  <= dav_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic stats_inc;

  // A transaction is counted when downstream completes the handshake.
  always_comb begin
    stats_inc = (state == DN_ACK) && !rfd;
  end

  // Per-source completion counters, free-running with natural 8-bit wrap.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (stats_inc) begin
      if (gnt) cnt1 <= cnt1 + 8'd1;
      else     cnt0 <= cnt0 + 8'd1;
    end
  end
`endif

endmodule
